// File: rtl/nes_pkg.sv
// Shared definitions for the cartridge save-RAM backup controller.
//   - state_e     : sequencer states
//   - sram_acc_t  : one latched SDRAM port-C access (direction, data, address)
//   - sector_count: image size in bytes -> number of 512 B sectors, clamped
package nes_pkg;

  localparam logic [6:0] SRAM_BASE_DEF = 7'b0001111;
  localparam int         LBA_W         = 6;   // sector index bits inside the save region
  localparam int         SEC_CNT_W     = 13;  // wide enough for img_size[20:9] + 1

  typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} state_e;

  typedef struct packed {
    logic        we;
    logic [7:0]  din;
    logic [21:0] addr;
  } sram_acc_t;

  // A partial trailing sector still needs a whole sector transfer.
  function automatic logic [SEC_CNT_W-1:0] sector_count(input logic [20:0]  size,
                                                         input int unsigned max_sec);
    logic [SEC_CNT_W-1:0] n;
    n = {1'b0, size[20:9]} + {{(SEC_CNT_W-1){1'b0}}, |size[8:0]};
    if (n > SEC_CNT_W'(max_sec)) n = SEC_CNT_W'(max_sec);
    return n;
  endfunction

endpackage

// File: rtl/sram_backup_ctrl_toggle_req.sv
// toggle_req: turns a one-cycle SD buffer strobe into a toggle-handshake
// SDRAM access. The access fields are latched together with the req toggle
// and stay stable until the next strobe.
//   clk, reset  : clock, async active-high reset
//   wr_stb_i    : SD byte arrived (SDRAM write, din_i valid)
//   rd_stb_i    : user_io wants a byte (SDRAM read)
//   din_i       : byte to write
//   addr_i      : SDRAM byte address for this access
//   ack_i       : toggles when the SDRAM finishes an access
//   req_o       : toggles once per access
//   acc_o       : latched {we, din, addr}
//   overrun_o   : sticky, a strobe arrived while an access was outstanding
module toggle_req
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_stb_i,
  input  logic        rd_stb_i,
  input  logic [7:0]  din_i,
  input  logic [21:0] addr_i,
  input  logic        ack_i,
  output logic        req_o,
  output sram_acc_t   acc_o,
  output logic        overrun_o
);

  logic      req_q;
  logic      overrun_q;
  sram_acc_t acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= 1'b0;
      overrun_q <= 1'b0;
      acc_q     <= '0;
    end else if (wr_stb_i || rd_stb_i) begin
      // The new access is issued anyway; the flag only records the loss.
      if (req_q != ack_i) overrun_q <= 1'b1;
      req_q      <= ~req_q;
      acc_q.addr <= addr_i;
      acc_q.we   <= wr_stb_i;
      if (wr_stb_i) acc_q.din <= din_i;
    end
  end

  assign req_o     = req_q;
  assign acc_o     = acc_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sram_backup_ctrl.sv
// sram_backup_ctrl: moves the battery-backed save image between the mounted
// SAV file (user_io sector interface) and the SDRAM save region.
//   Mount edge   -> load every sector of the image into SDRAM.
//   Save edge    -> write every sector back to the SD image.
//   Download edge-> disable backup; the sector in flight still finishes.
// Ports: img_mounted/img_size/save_req/downloading (control), sd_* (user_io
// sector interface), sram_* (SDRAM port C toggle handshake), bk_ena/busy/
// overrun (status). Read data for saves flows SDRAM -> user_io directly.
module sram_backup_ctrl
  import nes_pkg::*;
#(
  parameter logic [6:0]  SRAM_BASE   = SRAM_BASE_DEF,
  parameter int unsigned MAX_SECTORS = 16  // must fit in LBA_W bits of sector index
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        save_req,
  input  logic        downloading,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  input  logic        sd_buff_rd,
  input  logic [7:0]  sd_buff_dout,
  output logic [21:0] sram_addr,
  output logic        sram_req,
  input  logic        sram_ack,
  output logic        sram_we,
  output logic [7:0]  sram_din,
  output logic        bk_ena,
  output logic        busy,
  output logic        overrun
);

  logic mnt_q, save_q, dl_q, ack_q;
  logic mnt_rise_q, save_rise_q, dl_rise_q, ack_rise_q, ack_fall_q;
  state_e           state_q;
  logic             save_dir_q;   // 1 = SDRAM -> SD
  logic             load_pend_q, save_pend_q;
  logic             bk_ena_q, bk_ena_d;
  logic [LBA_W-1:0] sec_last_q;   // n-1
  logic [31:0]      sd_lba_q;
  logic             sd_rd_q, sd_wr_q;
  logic [SEC_CNT_W-1:0] n_cnt;
  logic             unused_size;

  assign unused_size = ^img_size[31:21];
  assign n_cnt       = sector_count(img_size[20:0], MAX_SECTORS);

  // A save edge coinciding with a valid mount is accepted: both pends set.
  always_comb begin
    bk_ena_d = bk_ena_q;
    if (mnt_rise_q) bk_ena_d = (n_cnt != '0);
    if (dl_rise_q)  bk_ena_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {mnt_q, save_q, dl_q, ack_q} <= '0;
      {mnt_rise_q, save_rise_q, dl_rise_q, ack_rise_q, ack_fall_q} <= '0;
      state_q     <= IDLE;
      save_dir_q  <= 1'b0;
      load_pend_q <= 1'b0;
      save_pend_q <= 1'b0;
      bk_ena_q    <= 1'b0;
      sec_last_q  <= '0;
      sd_lba_q    <= '0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
    end else begin
      mnt_q       <= img_mounted;
      save_q      <= save_req;
      dl_q        <= downloading;
      ack_q       <= sd_ack;
      mnt_rise_q  <= img_mounted & ~mnt_q;
      save_rise_q <= save_req & ~save_q;
      dl_rise_q   <= downloading & ~dl_q;
      ack_rise_q  <= sd_ack & ~ack_q;
      ack_fall_q  <= ~sd_ack & ack_q;

      case (state_q)
        IDLE: begin
          if (load_pend_q) begin
            load_pend_q <= 1'b0;
            save_dir_q  <= 1'b0;
            sd_lba_q    <= '0;
            sd_rd_q     <= 1'b1;
            state_q     <= REQ;
          end else if (save_pend_q) begin
            save_pend_q <= 1'b0;
            save_dir_q  <= 1'b1;
            sd_lba_q    <= '0;
            sd_wr_q     <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (ack_rise_q) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (ack_fall_q) state_q <= NEXT;
        end
        NEXT: begin
          if (!bk_ena_q || sd_lba_q == 32'(sec_last_q)) begin
            state_q <= IDLE;
          end else begin
            sd_lba_q <= sd_lba_q + 32'd1;
            sd_rd_q  <= ~save_dir_q;
            sd_wr_q  <= save_dir_q;
            state_q  <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Event updates follow the FSM so a fresh edge re-arms a pend it just consumed.
      bk_ena_q <= bk_ena_d;
      if (mnt_rise_q && n_cnt != '0) begin
        load_pend_q <= 1'b1;
        sec_last_q  <= n_cnt[LBA_W-1:0] - LBA_W'(1);
      end
      if (save_rise_q && bk_ena_d) save_pend_q <= 1'b1;
      if (dl_rise_q) begin
        load_pend_q <= 1'b0;
        save_pend_q <= 1'b0;
      end
    end
  end

  sram_acc_t acc;

  toggle_req u_toggle_req (
    .clk       (clk),
    .reset     (reset),
    .wr_stb_i  (sd_buff_wr),
    .rd_stb_i  (sd_buff_rd),
    .din_i     (sd_buff_dout),
    .addr_i    ({SRAM_BASE, sd_lba_q[LBA_W-1:0], sd_buff_addr}),
    .ack_i     (sram_ack),
    .req_o     (sram_req),
    .acc_o     (acc),
    .overrun_o (overrun)
  );

  assign sram_addr = acc.addr;
  assign sram_we   = acc.we;
  assign sram_din  = acc.din;
  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign bk_ena    = bk_ena_q;
  assign busy      = (state_q != IDLE);

endmodule
